// File: rtl/xpb_acc_pkg.sv
// Shared constants and state encoding for the xpb carry-save accumulator.
package xpb_acc_pkg;

  localparam int DATA_W    = 1024;
  localparam int MAX_TERMS = 64;
  localparam int SEG_W     = 128;
  localparam int ACC_W     = DATA_W + $clog2(MAX_TERMS);
  localparam int NSEG      = (ACC_W + SEG_W - 1) / SEG_W;
  localparam int SEG_IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int CNT_W     = (MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/xpb_accumulator_csa.sv
// Bitwise 3:2 compressor; carry is returned already weighted (shifted left by one),
// with the carry out of the top bit dropped.
module csa_3to2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  assign carry[0] = 1'b0;

  for (genvar gi = 0; gi < W; gi++) begin : g_sum
    assign sum[gi] = a[gi] ^ b[gi] ^ c[gi];
  end

  for (genvar gi = 0; gi < W - 1; gi++) begin : g_carry
    assign carry[gi+1] = (a[gi] & b[gi]) | (a[gi] & c[gi]) | (b[gi] & c[gi]);
  end

endmodule

// File: rtl/xpb_accumulator.sv
// Carry-save accumulator for xpb words with a segmented carry-propagate resolve.
// Optional input register stage: define XPB_ACC_IN_REG_EN.
module xpb_accumulator
  import xpb_acc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              ovf
);

  state_t                 state_reg;
  logic [ACC_W-1:0]       sum_reg;
  logic [ACC_W-1:0]       carry_reg;
  logic [ACC_W-1:0]       out_data_reg;
  logic [CNT_W-1:0]       term_cnt_reg;
  logic [SEG_IDX_W-1:0]   seg_idx_reg;
  logic                   cin_reg;
  logic                   in_ready_reg;
  logic                   out_valid_reg;
  logic                   ovf_reg;

  logic                   accept;
  logic                   close_term;
  logic                   add_en;
  logic                   close_now;
  logic [DATA_W-1:0]      add_data;
  logic [ACC_W-1:0]       csa_sum;
  logic [ACC_W-1:0]       csa_carry;

  assign accept     = in_valid & in_ready_reg;
  assign close_term = in_last | (term_cnt_reg == CNT_W'(MAX_TERMS - 1));

`ifdef XPB_ACC_IN_REG_EN
  logic              pend_valid_reg;
  logic              pend_last_reg;
  logic [DATA_W-1:0] pend_data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid_reg <= 1'b0;
      pend_last_reg  <= 1'b0;
      pend_data_reg  <= '0;
    end else begin
      pend_valid_reg <= accept;
      if (accept) begin
        pend_data_reg <= in_data;
        pend_last_reg <= close_term;
      end
    end
  end

  assign add_en    = pend_valid_reg;
  assign add_data  = pend_data_reg;
  assign close_now = pend_valid_reg & pend_last_reg;
`else
  assign add_en    = accept;
  assign add_data  = in_data;
  assign close_now = accept & close_term;
`endif

  csa_3to2 #(.W(ACC_W)) u_csa (
    .a     (sum_reg),
    .b     (carry_reg),
    .c     (ACC_W'(add_data)),
    .sum   (csa_sum),
    .carry (csa_carry)
  );

  // One SEG_W slice of the carry-save pair per cycle; the shifts truncate the top slice.
  int unsigned            seg_shift;
  logic [SEG_W-1:0]       seg_a;
  logic [SEG_W-1:0]       seg_b;
  logic [SEG_W:0]         seg_add;
  logic [ACC_W-1:0]       seg_mask;
  logic [ACC_W-1:0]       out_data_next;

  always_comb begin
    seg_shift     = 32'(seg_idx_reg) * SEG_W;
    seg_a         = SEG_W'(sum_reg >> seg_shift);
    seg_b         = SEG_W'(carry_reg >> seg_shift);
    seg_add       = {1'b0, seg_a} + {1'b0, seg_b} + (SEG_W + 1)'(cin_reg);
    seg_mask      = ACC_W'({SEG_W{1'b1}}) << seg_shift;
    out_data_next = (out_data_reg & ~seg_mask) | (ACC_W'(seg_add[SEG_W-1:0]) << seg_shift);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ACCUM;
      sum_reg       <= '0;
      carry_reg     <= '0;
      out_data_reg  <= '0;
      term_cnt_reg  <= '0;
      seg_idx_reg   <= '0;
      cin_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      ovf_reg <= 1'b0;
      case (state_reg)
        ACCUM: begin
          if (add_en) begin
            sum_reg   <= csa_sum;
            carry_reg <= csa_carry;
          end
          if (accept) begin
            term_cnt_reg <= term_cnt_reg + 1'b1;
            if (close_term) begin
              in_ready_reg <= 1'b0;
              ovf_reg      <= ~in_last;
            end
          end
          if (close_now) begin
            state_reg   <= RESOLVE;
            seg_idx_reg <= '0;
            cin_reg     <= 1'b0;
          end
        end
        RESOLVE: begin
          out_data_reg <= out_data_next;
          cin_reg      <= seg_add[SEG_W];
          if (seg_idx_reg == SEG_IDX_W'(NSEG - 1)) begin
            seg_idx_reg   <= '0;
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end else begin
            seg_idx_reg <= seg_idx_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            sum_reg       <= '0;
            carry_reg     <= '0;
            term_cnt_reg  <= '0;
            seg_idx_reg   <= '0;
            cin_reg       <= 1'b0;
            state_reg     <= ACCUM;
          end
        end
        default: begin
          state_reg     <= ACCUM;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign ovf       = ovf_reg;

endmodule

// File: doc/xpb_accumulator.md
Name: xpb_accumulator

Overview:
- Downstream consumer of the xpb lookup stages in the modular-square reduction path.
- Accepts a stream of DATA_W-bit precomputed reduction words, one per handshake, and accumulates them in carry-save form.
- Resolves the carry-save pair into one binary sum with a segmented carry-propagate adder, then presents the sum for the next reduction step.

Parameters:
- DATA_W, 1024, width of each incoming xpb word.
- MAX_TERMS, 64, maximum number of terms per accumulation.
- SEG_W, 128, carry-propagate segment width; one segment per clock.
- ACC_W, DATA_W+$clog2(MAX_TERMS) (1030), accumulator and result width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  DATA_W  xpb word to add.
- in_last  in  1  marks the final term of the current accumulation.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- out_data  out  ACC_W  resolved sum of all terms.
- ovf  out  1  one-cycle pulse: MAX_TERMS reached without in_last.

Behaviour:
- Reset (async, active-high): state=ACCUM; sum and carry regs=0; term_cnt=0; seg_idx=0; out_data=0; out_valid=0; ovf=0; in_ready=1 on the first cycle after reset deasserts.
- NSEG=ceil(ACC_W/SEG_W)=9 at defaults.
- States: ACCUM -> RESOLVE -> DONE -> ACCUM.
- ACCUM:
  - in_ready=1.
  - On in_valid&in_ready, a 3:2 CSA updates {sum,carry} with zero-extended in_data. The carry vector is shifted left by 1, and bits beyond ACC_W are dropped.
  - term_cnt increments on each accepted word.
  - Go to RESOLVE if in_last=1, or if term_cnt==MAX_TERMS-1 (forced close; ovf pulses on the next cycle if in_last=0).
- RESOLVE:
  - in_ready=0.
  - Each cycle adds segment seg_idx of sum, segment seg_idx of carry, and the registered carry-in. The result goes into the same segment of out_data; carry-out is registered.
  - seg_idx counts 0..NSEG-1. The top segment is truncated to ACC_W, and its final carry-out is discarded (it cannot be set for up to MAX_TERMS terms).
  - After segment NSEG-1, go to DONE.
- DONE:
  - out_valid=1; out_data is stable; in_ready=0.
  - On out_ready=1: out_valid drops next cycle; sum, carry, term_cnt, seg_idx and carry-in are cleared; return to ACCUM.
- Latency: out_valid rises NSEG clock edges after the edge that accepted the last term (9 at defaults).
- Throughput: one accumulation in flight at a time; no overlap of ACCUM with RESOLVE/DONE.
- A single term with in_last=1 is legal. A zero-term accumulation is impossible.
- in_valid while in_ready=0 is ignored; the word is not consumed.
- If out_ready is already high when DONE is entered, the result is accepted on that cycle: out_valid is high for exactly one cycle.
- Reset asserted mid-RESOLVE or mid-DONE aborts the accumulation; everything returns to reset values and no partial result is emitted.

Optional Feature:
- Macro: XPB_ACC_IN_REG_EN.
- Defined:
  - in_data and in_last pass through a register stage before the CSA; in_ready still reflects state ACCUM.
  - The transition to RESOLVE waits until the registered last term has been added.
  - Latency from last accept to out_valid becomes NSEG+1.
  - A word pending in the register stage is cleared by reset.
- Undefined: combinational in_data into the CSA; latency NSEG.

Decomposition:
- Package xpb_acc_pkg holds:
  - constants DATA_W, MAX_TERMS, ACC_W, SEG_W, NSEG;
  - enum state_t {ACCUM, RESOLVE, DONE};
  - segment index width localparam.
- One sub-module: csa_3to2, a parameterised-width bitwise full-adder array returning sum and carry vectors. It is instantiated once at ACC_W.

Test Plan:
- Single term in_data=1, in_last=1 -> out_valid after 9 cycles, out_data=1, ovf=0.
- Two terms of 2^1024-1 (last on the second) -> out_data=2^1025-2.
- 64 terms of 2^1024-1 with in_last on the 64th -> out_data=64*(2^1024-1), i.e. bit 1030 is not needed; ovf=0.
- 64 terms of 1 with in_last never asserted -> forced close, ovf pulses one cycle, out_data=64, and the next in_data (value 5, last) yields out_data=5.
- out_ready held low 5 cycles in DONE -> out_valid and out_data constant, in_ready=0 throughout. On out_ready=1, out_valid drops and in_ready=1 on the next cycle.
- rst pulsed at RESOLVE segment 3 after terms 7 and 9 -> out_valid stays 0. A new term 3 with last then yields out_data=3, not 19.
